// File: rtl/usb_pkg.sv
// Shared USB link-layer types and constants.
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    STUFF = 2'd2
  } bs_state_t;

  localparam int USB_STUFF_RUN = 6;

endpackage

// File: rtl/usb_bit_stuffer.sv
// Serial USB bit stuffer: inserts a 0 after every RUN_LEN consecutive 1s,
// stalling upstream for one cycle per inserted bit.
module usb_bit_stuffer
  import usb_pkg::*;
#(
  parameter int RUN_LEN     = USB_STUFF_RUN,
  parameter int STUFF_CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_bit,
  input  logic                   in_valid,
  output logic                   bs_ready,
  output logic                   out_bit,
  output logic                   out_valid,
  output logic                   eop,
  output logic [STUFF_CNT_W-1:0] stuff_cnt
);

  localparam int OW = $clog2(RUN_LEN + 1);
  localparam logic [OW-1:0] RUN_MAX = OW'(RUN_LEN);

  bs_state_t     state;
  logic [OW-1:0] ones_cnt;
  logic [OW-1:0] ones_base;
  logic [OW-1:0] ones_nxt;
  logic          accept;
  logic          run_hit;

  assign bs_ready  = (state != STUFF);
  assign accept    = bs_ready && in_valid;
  // A new packet always starts its run from zero.
  assign ones_base = (state == IDLE) ? '0 : ones_cnt;
  assign ones_nxt  = in_bit ? ones_base + 1'b1 : '0;
  assign run_hit   = in_bit && (ones_nxt == RUN_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ones_cnt <= '0;
    end else if (accept) begin
      ones_cnt <= ones_nxt;
    end else if (state == STUFF || (state == PASS && !in_valid)) begin
      ones_cnt <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stuff_cnt <= '0;
    end else if (state == IDLE && in_valid) begin
      stuff_cnt <= '0;
    end else if (state == STUFF && stuff_cnt != '1) begin
      stuff_cnt <= stuff_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      eop       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          eop       <= 1'b0;
          out_valid <= 1'b0;
          if (in_valid) begin
            out_bit   <= in_bit;
            out_valid <= 1'b1;
            state     <= run_hit ? STUFF : PASS;
          end
        end
        PASS: begin
          if (in_valid) begin
            out_bit   <= in_bit;
            out_valid <= 1'b1;
            eop       <= 1'b0;
            state     <= run_hit ? STUFF : PASS;
          end else begin
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            eop       <= 1'b1;
            state     <= IDLE;
          end
        end
        STUFF: begin
          // Upstream holds its bit; it is taken on the return to PASS.
          out_bit   <= 1'b0;
          out_valid <= 1'b1;
          eop       <= 1'b0;
          state     <= PASS;
        end
        default: begin
          out_bit   <= 1'b0;
          out_valid <= 1'b0;
          eop       <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_bit_stuffer.sv
// Directed bench for usb_bit_stuffer: output streams, stalls, eop timing, counters.
module tb_usb_bit_stuffer;

  logic       clock;
  logic       reset_n;
  logic       in_bit;
  logic       in_valid;
  logic       bs_ready;
  logic       out_bit;
  logic       out_valid;
  logic       eop;
  logic [7:0] stuff_cnt;

  int         errs;
  int         checks;
  int         cyc;
  logic [31:0] got;
  int         got_len;
  int         eop_cnt, eop_cyc, stall_cnt, stall_cyc;
  int         first_valid, last_valid, acc0;

  usb_bit_stuffer #(.RUN_LEN(6), .STUFF_CNT_W(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .bs_ready (bs_ready),
    .out_bit  (out_bit),
    .out_valid(out_valid),
    .eop      (eop),
    .stuff_cnt(stuff_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    got = '0; got_len = 0;
    eop_cnt = 0; eop_cyc = -1; stall_cnt = 0; stall_cyc = -1;
    first_valid = -1; last_valid = -1; acc0 = -1;
  endtask

  // One clock; outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clock);
    cyc++;
    @(negedge clock);
    if (reset_n) begin
      if (out_valid) begin
        got = {got[30:0], out_bit};
        got_len++;
        last_valid = cyc;
        if (first_valid < 0) first_valid = cyc;
      end
      if (eop) begin
        eop_cnt++;
        eop_cyc = cyc;
      end
      if (!bs_ready) begin
        stall_cnt++;
        stall_cyc = cyc;
      end
    end
  endtask

  // Present n bits MSB first, honouring bs_ready, then idle a few cycles.
  task automatic send(input logic [31:0] bits, input int n);
    int i;
    int guard;
    i = 0; guard = 0;
    while (i < n && guard < 100) begin
      in_valid = 1'b1;
      in_bit   = bits[n-1-i];
      if (bs_ready) begin
        if (i == 0) acc0 = cyc + 1;
        i++;
      end
      tick();
      guard++;
    end
    if (guard >= 100) check("send_timeout", 32'(guard), 32'(n));
    in_valid = 1'b0;
    in_bit   = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    errs = 0; checks = 0; cyc = 0;
    clr();
    reset_n = 1'b0; in_bit = 1'b0; in_valid = 1'b0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_eop", 32'(eop), 32'd0);
    check("rst_stuff_cnt", 32'(stuff_cnt), 32'd0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("rst_bs_ready", 32'(bs_ready), 32'd1);

    // No stuffing
    clr(); send(32'hA5, 8);
    check("ns_stream", got, 32'hA5);
    check("ns_len", 32'(got_len), 32'd8);
    check("ns_stalls", 32'(stall_cnt), 32'd0);
    check("ns_latency", 32'(first_valid - acc0), 32'd0);
    check("ns_eop_cnt", 32'(eop_cnt), 32'd1);
    check("ns_eop_gap", 32'(eop_cyc - last_valid), 32'd1);
    check("ns_stuff_cnt", 32'(stuff_cnt), 32'd0);

    // Single stuff inside the packet
    clr(); send(32'hFF, 8);
    check("ss_stream", got, 32'b111111011);
    check("ss_len", 32'(got_len), 32'd9);
    check("ss_stalls", 32'(stall_cnt), 32'd1);
    check("ss_stall_pos", 32'(stall_cyc - first_valid), 32'd5);
    check("ss_eop_cnt", 32'(eop_cnt), 32'd1);
    check("ss_stuff_cnt", 32'(stuff_cnt), 32'd1);

    // Trailing stuff
    clr(); send(32'h3F, 6);
    check("ts_stream", got, 32'b1111110);
    check("ts_len", 32'(got_len), 32'd7);
    check("ts_eop_gap", 32'(eop_cyc - last_valid), 32'd1);
    check("ts_stuff_cnt", 32'(stuff_cnt), 32'd1);

    // Two full runs
    clr(); send(32'hFFF, 12);
    check("r12_stream", got, 32'b11111101111110);
    check("r12_len", 32'(got_len), 32'd14);
    check("r12_stalls", 32'(stall_cnt), 32'd2);
    check("r12_stuff_cnt", 32'(stuff_cnt), 32'd2);

    // Runs of five broken by a 0 never stuff
    clr(); send(32'b11111011111, 11);
    check("r5_stream", got, 32'b11111011111);
    check("r5_len", 32'(got_len), 32'd11);
    check("r5_stalls", 32'(stall_cnt), 32'd0);
    check("r5_stuff_cnt", 32'(stuff_cnt), 32'd0);

    // Reset while in the second STUFF of a 12-ones packet
    clr();
    in_valid = 1'b1; in_bit = 1'b1;
    for (int k = 0; k < 40 && stall_cnt < 2; k++) tick();
    check("rs_reached_stuff", 32'(stall_cnt), 32'd2);
    check("rs_pre_cnt", 32'(stuff_cnt), 32'd1);
    #2 reset_n = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0;
    #1;
    check("rs_out_valid", 32'(out_valid), 32'd0);
    check("rs_eop", 32'(eop), 32'd0);
    check("rs_stuff_cnt", 32'(stuff_cnt), 32'd0);
    check("rs_bs_ready", 32'(bs_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    clr(); send(32'hF, 4);
    check("rs_stream", got, 32'hF);
    check("rs_len", 32'(got_len), 32'd4);
    check("rs_stalls", 32'(stall_cnt), 32'd0);
    check("rs_new_cnt", 32'(stuff_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/usb_bit_stuffer.md
Name: usb_bit_stuffer

Overview:
Serial USB bit stuffer that sits directly downstream of the CRC calculator and upstream of the NRZI encoder. It consumes the serial packet-plus-CRC bit stream and inserts a 0 after every run of RUN_LEN consecutive 1s. It stalls the upstream stage with bs_ready for exactly one cycle per inserted bit. It also reports end of packet and a per-packet count of stuffed bits.

Parameters:
RUN_LEN, 6, number of consecutive 1s that triggers insertion of a stuffed 0 (legal range 1..15).
STUFF_CNT_W, 8, width of the per-packet stuffed-bit counter.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  reset, asynchronous, active-low.
in_bit  input  1  serial data bit from the CRC stage; held stable by upstream while bs_ready=0.
in_valid  input  1  upstream presenting a packet bit this cycle; low between packets.
bs_ready  output  1  stuffer accepts in_bit this cycle; Moore output from state only.
out_bit  output  1  registered serial bit to the NRZI encoder.
out_valid  output  1  out_bit is a valid packet or stuffed bit.
eop  output  1  one-cycle pulse, the cycle after the last valid out_bit of a packet.
stuff_cnt  output  STUFF_CNT_W  stuffed bits inserted in the current or last packet; saturating.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, out_bit=0, out_valid=0, eop=0, stuff_cnt=0, ones_cnt=0. bs_ready=1 once state is IDLE.
- ones_cnt width is $clog2(RUN_LEN+1).
- Accept rule: a bit is accepted on a rising edge where bs_ready=1 and in_valid=1.
- Accepted bit appears on out_bit with out_valid=1 on the next cycle (latency 1).
- ones_cnt update on accept: in_bit=1 gives ones_cnt+1; in_bit=0 gives 0.
- States: IDLE, PASS, STUFF.
- bs_ready is 1 in IDLE and PASS, and 0 in STUFF.
- IDLE: eop<=0, out_valid<=0.
  - in_valid=1: accept the bit, stuff_cnt<=0, ones_cnt starts from 0 for this packet, go to PASS.
- PASS, in_valid=1: accept the bit.
  - If the accepted bit makes ones_cnt==RUN_LEN, go to STUFF; otherwise stay in PASS.
- PASS, in_valid=0 (end of packet): out_valid<=0, eop<=1, ones_cnt<=0, go to IDLE.
- STUFF (entered the cycle after the RUN_LEN-th 1 was accepted; that 1 is on out_bit this cycle):
  - Drive out_bit<=0, out_valid<=1, ones_cnt<=0.
  - stuff_cnt<=stuff_cnt+1, saturating at all-ones.
  - in_valid is ignored and upstream holds its bit.
  - Go to PASS.
- Trailing stuff: if the packet's final bits are RUN_LEN 1s, the stuffed 0 is still emitted. eop follows the stuffed bit.
- A stuffed 0 itself resets the run. Input 0s never cause stuffing.
- Back-to-back packets: IDLE with in_valid=1 accepts immediately. The eop of the previous packet and the first out_valid=0 gap coincide, giving a minimum one-cycle gap between packets.
- Reset mid-operation (any state): all outputs return to reset values immediately, and the partial packet is discarded.
- in_valid rising while in STUFF is not a new packet; it is treated as continuation.

Decomposition:
- Shared package usb_pkg holds:
  - bs_state_t enum {IDLE, PASS, STUFF};
  - localparam USB_STUFF_RUN = 6, which RUN_LEN defaults to.
- No sub-module is needed. The ones counter and stuff counter are inline always_ff blocks alongside the FSM.

Test Plan:
- Reset: assert reset_n=0 mid-cycle -> out_valid=0, eop=0, stuff_cnt=0 immediately; bs_ready=1 after release.
- No stuffing: send 8'b1010_0101 with in_valid held 8 cycles -> identical 8 bits on out_bit one cycle later, bs_ready never low, eop pulse on cycle 10, stuff_cnt=0.
- Single stuff: send 8 ones -> out stream 1111110 11 (9 valid bits), bs_ready low exactly one cycle (the cycle after the 6th 1 is accepted), upstream bit 7 held and accepted next, stuff_cnt=1.
- Trailing stuff: send exactly 6 ones then drop in_valid -> out stream 1111110, eop one cycle after the stuffed 0, stuff_cnt=1.
- Run boundaries: send 12 ones -> 111111 0 111111 0, stuff_cnt=2. Send 11111 0 11111 -> 11 bits unchanged, stuff_cnt=0.
- Reset during STUFF, then send packet 1111 -> outputs cleared at reset; new packet emits 1111 with no stuffing (ones_cnt restarted), stuff_cnt=0.
